// File: rtl/bp_gshare_predictor_if.sv
// Fetch-side bundle for the gshare predictor: the current fetch address,
// the training return path from branch resolution, and the prediction results.
`timescale 1ns/1ps
interface bp_gshare_predictor_if #(
    parameter int IDX_W = 6
);
    logic [31:0]      eip;
    logic             prev_BR_result;
    logic [IDX_W-1:0] prev_BR_alias;
    logic             prev_is_BR;
    logic             LD;
    logic             prediction;
    logic [IDX_W-1:0] BP_alias;
    logic [IDX_W-1:0] GBHR;

    // There is no handshake. Inputs are sampled on every rising clock edge.
    // Outputs are valid combinationally in every cycle.
    modport master (
        output eip, prev_BR_result, prev_BR_alias, prev_is_BR, LD,
        input  prediction, BP_alias, GBHR
    );

    modport slave (
        input  eip, prev_BR_result, prev_BR_alias, prev_is_BR, LD,
        output prediction, BP_alias, GBHR
    );
endinterface

// File: rtl/bp_gshare_predictor.sv
// Gshare branch predictor: the fetch EIP is XORed with the global history to index
// 2-bit saturating counters; resolved branches train the counter and shift the history.
`timescale 1ns/1ps
module bp_gshare_predictor #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic                    clk,
    input  logic                    reset,
    bp_gshare_predictor_if.slave    bp
);
    localparam int N_ENT = 1 << IDX_W;

    logic [1:0]       pht_q [N_ENT];
    logic [1:0]       pht_d [N_ENT];
    logic [IDX_W-1:0] gbhr_q;
    logic [IDX_W-1:0] gbhr_d;
    logic [IDX_W-1:0] alias_idx;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_nxt;
    logic             upd_en;
    logic             unused_eip_hi;

    assign unused_eip_hi = ^bp.eip[31:IDX_W];

    assign alias_idx     = bp.eip[IDX_W-1:0] ^ gbhr_q;
    assign bp.BP_alias   = alias_idx;
    assign bp.GBHR       = gbhr_q;
    // Gated by reset so the output is 0 during reset for any CTR_INIT value.
    assign bp.prediction = reset & pht_q[alias_idx][1];

    assign upd_en = bp.LD & bp.prev_is_BR;

    always_comb begin
        pht_d   = pht_q;
        gbhr_d  = gbhr_q;
        ctr_cur = pht_q[bp.prev_BR_alias];
        ctr_nxt = ctr_cur;
        if (upd_en) begin
            if (bp.prev_BR_result) begin
                ctr_nxt = (ctr_cur == 2'b11) ? ctr_cur : ctr_cur + 2'd1;
            end else begin
                ctr_nxt = (ctr_cur == 2'b00) ? ctr_cur : ctr_cur - 2'd1;
            end
            pht_d[bp.prev_BR_alias] = ctr_nxt;
            gbhr_d = {gbhr_q[IDX_W-2:0], bp.prev_BR_result};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ENT; i++) begin
                pht_q[i] <= CTR_INIT;
            end
            gbhr_q <= '0;
        end else begin
            pht_q  <= pht_d;
            gbhr_q <= gbhr_d;
        end
    end
endmodule

// File: tb/tb_bp_gshare_predictor.sv
// Scoreboard bench for bp_gshare_predictor: a table/history model predicts the outputs
// for each driven cycle, and a negedge monitor compares the DUT outputs against them.
`timescale 1ns/1ps
module tb_bp_gshare_predictor;
    localparam int IDX_W = 6;
    localparam int N_ENT = 64;
    localparam int EW    = 2 * IDX_W + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_gshare_predictor_if #(.IDX_W(IDX_W)) bus ();

    bp_gshare_predictor #(.IDX_W(IDX_W), .CTR_INIT(2'b01)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bus)
    );

    int m_pht [N_ENT];
    int m_ghist;
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_ENT; i++) m_pht[i] = 1;
        m_ghist = 0;
    endtask

    function automatic logic [EW-1:0] model_expect(logic [31:0] eip, logic rst_n);
        int idx;
        logic p;
        idx = int'(eip & 32'h3F) ^ m_ghist;
        p   = rst_n && (m_pht[idx] >= 2);
        return {p, idx[IDX_W-1:0], m_ghist[IDX_W-1:0]};
    endfunction

    // Called just after a rising edge: drive, predict, then let the edge train the model.
    task automatic step(input logic [31:0] eip, input logic rst_n, input logic ld,
                        input logic is_br, input logic res, input logic [5:0] al);
        reset              = rst_n;
        bus.eip            = eip;
        bus.LD             = ld;
        bus.prev_is_BR     = is_br;
        bus.prev_BR_result = res;
        bus.prev_BR_alias  = al;
        if (!rst_n) model_reset();
        exp_q.push_back(model_expect(eip, rst_n));
        @(posedge clk);
        if (rst_n && ld && is_br) begin
            if (res) m_pht[al] = (m_pht[al] >= 3) ? 3 : m_pht[al] + 1;
            else     m_pht[al] = (m_pht[al] <= 0) ? 0 : m_pht[al] - 1;
            m_ghist = ((m_ghist << 1) | int'(res)) & 63;
        end
        #2;
    endtask

    function automatic logic [31:0] eip_for(int entry);
        return 32'(entry ^ m_ghist);
    endfunction

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("prediction", int'(bus.prediction), int'(e[EW-1]));
            check("BP_alias", int'(bus.BP_alias), int'(e[EW-2:IDX_W]));
            check("GBHR", int'(bus.GBHR), int'(e[IDX_W-1:0]));
        end
    end

    initial begin
        logic [31:0] r_eip;
        logic [5:0]  hot;
        reset              = 1'b0;
        bus.eip            = 32'h0;
        bus.LD             = 1'b0;
        bus.prev_is_BR     = 1'b0;
        bus.prev_BR_result = 1'b0;
        bus.prev_BR_alias  = '0;
        model_reset();
        @(posedge clk);
        #2;

        // reset state and release
        step(32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        step(32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);

        // two taken trainings of 0x38, then look it up through the new history
        step(32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 6'h38);
        step(32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 6'h38);
        step(32'h0000003B, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);

        // saturation at both ends of entry 0x05
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        for (int i = 0; i < 4; i++) step(eip_for(5), 1'b1, 1'b1, 1'b1, 1'b0, 6'h05);
        step(eip_for(5), 1'b1, 1'b1, 1'b1, 1'b1, 6'h05);
        step(eip_for(5), 1'b1, 1'b0, 1'b0, 1'b0, 6'h05);
        for (int i = 0; i < 3; i++) step(eip_for(5), 1'b1, 1'b1, 1'b1, 1'b1, 6'h05);
        step(eip_for(5), 1'b1, 1'b0, 1'b0, 1'b0, 6'h05);

        // stalls and non-branches must not train; then scan the entire table
        for (int i = 0; i < 3; i++) begin
            step($urandom, 1'b1, 1'b0, 1'b1, 1'b1, 6'($urandom_range(0, 63)));
            step($urandom, 1'b1, 1'b1, 1'b0, 1'b1, 6'($urandom_range(0, 63)));
        end
        for (int i = 0; i < N_ENT; i++) step(eip_for(i), 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);

        // same-cycle read and write of one entry: no bypass
        step(eip_for(16), 1'b1, 1'b1, 1'b1, 1'b1, 6'h10);
        step(eip_for(16), 1'b1, 1'b1, 1'b1, 1'b1, 6'h10);
        step(eip_for(16), 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);

        // asynchronous reset discards learned state before any clock edge
        step(eip_for(16), 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        step(32'h00000010, 1'b0, 1'b1, 1'b1, 1'b1, 6'h10);
        step(32'h00000038, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00);

        // randomized traffic concentrated on a small set of entries
        for (int i = 0; i < 500; i++) begin
            hot   = 6'($urandom_range(0, 7));
            r_eip = $urandom;
            if ($urandom_range(0, 1) == 1) r_eip = {r_eip[31:6], hot ^ m_ghist[5:0]};
            step(r_eip, ($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0) ? hot : 6'($urandom_range(0, 63)));
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
